// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_pkg
//  Description : Shared definitions for the Sobel window reader/writer pair:
//                reader FSM state encoding, default image geometry and the
//                mapping from (row, column) tap position to packed index.
//  Revision    : 1.0  initial release
// ============================================================================
package sobel_pkg;

    localparam int DEF_IMG_WIDTH  = 256;
    localparam int DEF_IMG_HEIGHT = 256;
    localparam int DEF_DATA_W     = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2,
        S_END  = 2'd3
    } state_t;

    // Packed slot of tap (r, c); row 0 / column 0 is the oldest pixel.
    function automatic int tap_idx(input int r, input int c);
        return 3 * r + c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/raster_counter.sv
`default_nettype none
// ============================================================================
//  Module      : raster_counter
//  Description : Column/row raster position counter with wrap. Reports the
//                position of the pixel offered this cycle and strobes when
//                that pixel closes a line or closes the frame.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                advance       - a pixel is consumed this cycle
//                col, row      - position of the pixel being consumed
//                line_end      - advance on the last column
//                frame_end     - advance on the last pixel of the frame
//  Revision    : 1.0  initial release
// ============================================================================
module raster_counter
    import sobel_pkg::*;
#(
    parameter  int WIDTH  = DEF_IMG_WIDTH,
    parameter  int HEIGHT = DEF_IMG_HEIGHT,
    localparam int COL_W  = $clog2(WIDTH),
    localparam int ROW_W  = $clog2(HEIGHT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             line_end,
    output logic             frame_end
);

    localparam logic [COL_W-1:0] c_col_last = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] c_row_last = ROW_W'(HEIGHT - 1);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;

    assign line_end  = advance && (r_col == c_col_last);
    assign frame_end = line_end && (r_row == c_row_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (advance) begin
            if (r_col == c_col_last) begin
                r_col <= '0;
                r_row <= (r_row == c_row_last) ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign col = r_col;
    assign row = r_row;

endmodule
`default_nettype wire

// File: rtl/sobel_window_reader.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_window_reader
//  Description : Consumes one column of three vertically aligned pixels per
//                enabled cycle (current row plus two line-buffer outputs) and
//                assembles a registered 3x3 neighbourhood. WindowValid marks
//                windows lying fully inside the image; FrameDone pulses with
//                the last window of a frame.
//  Ports       : CLK, RST                 - clock, synchronous active-high reset
//                Enable                   - column presented; low = stall
//                Row0In/Row1In/Row2In     - oldest / middle / newest row pixel
//                Window                   - 9 taps, slot 3*r+c, DATA_W each
//                WindowValid              - one-cycle qualifier for Window
//                FrameDone                - end-of-frame pulse
//  Options     : FRAME_DONE_EN - adds FrameDone, the END state and a 16-bit
//                debug frame counter.
//  Revision    : 1.0  initial release
// ============================================================================
module sobel_window_reader
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int DATA_W     = DEF_DATA_W
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                Enable,
    input  logic [DATA_W-1:0]   Row2In,
    input  logic [DATA_W-1:0]   Row1In,
    input  logic [DATA_W-1:0]   Row0In,
    output logic [9*DATA_W-1:0] Window,
    output logic                WindowValid
`ifdef FRAME_DONE_EN
    ,
    output logic                FrameDone
`endif
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);

    logic [COL_W-1:0]  w_col;
    logic [ROW_W-1:0]  w_row;
    logic              w_line_end;
    logic              w_frame_end;
    logic [DATA_W-1:0] r_tap [3][3];
    logic              r_valid;
    state_t            r_state;
    state_t            w_state_next;

    raster_counter #(
        .WIDTH  (IMG_WIDTH),
        .HEIGHT (IMG_HEIGHT)
    ) u_raster (
        .clk       (CLK),
        .rst       (RST),
        .advance   (Enable),
        .col       (w_col),
        .row       (w_row),
        .line_end  (w_line_end),
        .frame_end (w_frame_end)
    );

    // Tap shift register plus the valid qualifier. Validity is judged from
    // the position of the pixel being shifted in: the window is fully inside
    // the image only once two earlier rows and two earlier columns exist on
    // the same line, so columns 0 and 1 (which still hold the previous line's
    // tail) never qualify.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_tap[r][c] <= '0;
                end
            end
            r_valid <= 1'b0;
        end else begin
            if (Enable) begin
                for (int r = 0; r < 3; r++) begin
                    r_tap[r][0] <= r_tap[r][1];
                    r_tap[r][1] <= r_tap[r][2];
                end
                r_tap[0][2] <= Row0In;
                r_tap[1][2] <= Row1In;
                r_tap[2][2] <= Row2In;
            end
            r_valid <= Enable && (w_row >= ROW_W'(2)) && (w_col >= COL_W'(2));
        end
    end

    for (genvar gr = 0; gr < 3; gr++) begin : g_row
        for (genvar gc = 0; gc < 3; gc++) begin : g_col
            assign Window[DATA_W*tap_idx(gr, gc) +: DATA_W] = r_tap[gr][gc];
        end
    end

    assign WindowValid = r_valid;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (Enable) begin
                    w_state_next = S_FILL;
                end
            end
            S_FILL: begin
                // Leaving row 1 means the next pixel starts row 2.
                if (w_line_end && (w_row == ROW_W'(1))) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_frame_end) begin
`ifdef FRAME_DONE_EN
                    w_state_next = S_END;
`else
                    w_state_next = S_FILL;
`endif
                end
            end
            S_END: begin
                // An accept here is pixel (0,0) of the following frame.
                w_state_next = Enable ? S_FILL : S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

`ifdef FRAME_DONE_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_frame_cnt <= '0;
        end else if (w_frame_end) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    // END is held for exactly the cycle following the last pixel's accept,
    // which is also the cycle carrying the last valid window.
    assign FrameDone = (r_state == S_END);
`endif

endmodule
`default_nettype wire

// File: tb/tb_sobel_window_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sobel_window_reader
//  Description : Directed self-checking bench for sobel_window_reader on an
//                8x6 image with pixel value 8*r + c. Line-buffer outputs are
//                emulated by driving the pixels one and two rows above.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sobel_window_reader;

    localparam int W = 8;
    localparam int H = 6;
    localparam int D = 8;

    logic           CLK = 1'b0;
    logic           RST;
    logic           Enable;
    logic [D-1:0]   Row2In;
    logic [D-1:0]   Row1In;
    logic [D-1:0]   Row0In;
    logic [9*D-1:0] Window;
    logic           WindowValid;
`ifdef FRAME_DONE_EN
    logic           FrameDone;
`endif

    int checks = 0;
    int errors = 0;
    int valid_cnt;
    int cycle = 0;
    int fd_cnt;
    int fd_cycle [2];
    logic [9*D-1:0] last_win;
    bit             have_win;

    always #5 CLK = ~CLK;

    sobel_window_reader #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .DATA_W     (D)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .Enable      (Enable),
        .Row2In      (Row2In),
        .Row1In      (Row1In),
        .Row0In      (Row0In),
        .Window      (Window),
        .WindowValid (WindowValid)
`ifdef FRAME_DONE_EN
        ,
        .FrameDone   (FrameDone)
`endif
    );

    function automatic logic [D-1:0] pix(input int r, input int c);
        if (r < 0) return '0;
        return D'(8 * r + c);
    endfunction

    // Expected window after accepting pixel (r,c): rows r-2..r, cols c-2..c.
    function automatic logic [9*D-1:0] exp_win(input int r, input int c);
        logic [9*D-1:0] w;
        w = '0;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 3; j++) begin
                w[D*(3*k+j) +: D] = pix(r - 2 + k, c - 2 + j);
            end
        end
        return w;
    endfunction

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic accept_pixel(input int r, input int c);
        logic v;
        logic [9*D-1:0] ew;
        @(negedge CLK);
        RST    = 1'b0;
        Enable = 1'b1;
        Row2In = pix(r, c);
        Row1In = pix(r - 1, c);
        Row0In = pix(r - 2, c);
        @(posedge CLK);
        cycle++;
        #1;
        v  = (r >= 2) && (c >= 2);
        ew = exp_win(r, c);
        check($sformatf("valid(%0d,%0d)", r, c), 72'(WindowValid), 72'(v));
        if (WindowValid === 1'b1) valid_cnt++;
        if (v) begin
            check($sformatf("window(%0d,%0d)", r, c), 72'(Window), 72'(ew));
            last_win = ew;
        end
        have_win = v;
`ifdef FRAME_DONE_EN
        check($sformatf("frame_done(%0d,%0d)", r, c), 72'(FrameDone),
              72'((r == H-1) && (c == W-1)));
        if (FrameDone === 1'b1) begin
            if (fd_cnt < 2) fd_cycle[fd_cnt] = cycle;
            fd_cnt++;
        end
`endif
    endtask

    task automatic stall_cycle();
        @(negedge CLK);
        Enable = 1'b0;
        Row2In = D'($urandom);
        Row1In = D'($urandom);
        Row0In = D'($urandom);
        @(posedge CLK);
        cycle++;
        #1;
        check("stall_valid", 72'(WindowValid), 72'(0));
        if (have_win) check("stall_hold", 72'(Window), 72'(last_win));
`ifdef FRAME_DONE_EN
        check("stall_frame_done", 72'(FrameDone), 72'(0));
`endif
    endtask

    task automatic run_frame(input bit toggle);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                accept_pixel(r, c);
                if (toggle) stall_cycle();
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge CLK);
        RST    = 1'b1;
        Enable = 1'b1;
        @(posedge CLK);
        cycle++;
        #1;
        check("rst_window", 72'(Window), 72'(0));
        check("rst_valid", 72'(WindowValid), 72'(0));
`ifdef FRAME_DONE_EN
        check("rst_frame_done", 72'(FrameDone), 72'(0));
`endif
        have_win = 1'b0;
        @(negedge CLK);
        RST    = 1'b0;
        Enable = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RST      = 1'b1;
        Enable   = 1'b0;
        Row2In   = '0;
        Row1In   = '0;
        Row0In   = '0;
        have_win = 1'b0;
        fd_cnt   = 0;
        fd_cycle[0] = 0;
        fd_cycle[1] = 0;

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        check("reset_window", 72'(Window), 72'(0));
        check("reset_valid", 72'(WindowValid), 72'(0));
`ifdef FRAME_DONE_EN
        check("reset_frame_done", 72'(FrameDone), 72'(0));
`endif
        @(negedge CLK);
        RST = 1'b0;

        // Continuous frame
        valid_cnt = 0;
        run_frame(1'b0);
        check("frame1_valid_count", 72'(valid_cnt), 72'(24));
        check("frame1_last_centre", 72'(Window[D*4 +: D]), 72'(38));
        stall_cycle();

        // One-on / one-off enable over a full frame
        valid_cnt = 0;
        run_frame(1'b1);
        check("toggle_valid_count", 72'(valid_cnt), 72'(24));

        // Reset in the slot of pixel (3,4), then a full frame
        valid_cnt = 0;
        for (int i = 0; i < 3*W + 4; i++) accept_pixel(i / W, i % W);
        pulse_reset();
        valid_cnt = 0;
        run_frame(1'b0);
        check("after_reset_valid_count", 72'(valid_cnt), 72'(24));
        stall_cycle();

        // Two back-to-back frames
        valid_cnt = 0;
        fd_cnt    = 0;
        run_frame(1'b0);
        run_frame(1'b0);
        check("b2b_valid_count", 72'(valid_cnt), 72'(48));
`ifdef FRAME_DONE_EN
        check("b2b_frame_done_count", 72'(fd_cnt), 72'(2));
        check("b2b_frame_done_gap", 72'(fd_cycle[1] - fd_cycle[0]), 72'(48));
`endif
        stall_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
